score_max_tracker: RTL and testbench
====================================

// Module: score_max_tracker
// PURPOSE
//  Downstream of the 64-wide max-reduction tree (fixed 2-cycle latency, myMax rule).
//  Consumes one reduced score per PE-array beat. Tracks the running best local-alignment score and the beat index where it first occurs.
//  On the last beat of a query pass, drains the tree latency, then presents {best_score, best_pos} to the host controller on a valid/ready handshake.
// PARAMETERS
//  DATA_WIDTH  `V_E_F_Bit (18)  score width; MSB = sign flag, [DATA_WIDTH-2:0] = magnitude
//  TREE_LAT    2                cycles from tree input to tree result
//  POS_WIDTH   `Max_T_size_log  width of the beat/position counter
// PORTS
//  clk         in   1           clock
//  rst_n       in   1           asynchronous reset, active low
//  beat_valid  in   1           a PE vector is entering the tree this cycle
//  beat_last   in   1           qualifies beat_valid: final beat of the pass
//  beat_ready  out  1           tracker accepts beats (upstream must hold when low)
//  tree_max    in   DATA_WIDTH  tree result; belongs to beat issued TREE_LAT cycles earlier
//  res_valid   out  1           best_score/best_pos valid
//  res_ready   in   1           consumer accepts result
//  best_score  out  DATA_WIDTH  pass maximum, clamped >= 0
//  best_pos    out  POS_WIDTH   beat index (0-based) of first occurrence of best_score
//  drop_err    out  1           sticky: beat_valid seen while beat_ready low
// BEHAVIOUR
//  Reset: state IDLE; beat_ready=1; res_valid=0; best_score=0; best_pos=0; drop_err=0. Delay line cleared.
//  Delay line: TREE_LAT-deep shift of {valid,last,pos}. It is loaded with beat_valid&beat_ready, beat_last, and the position counter.
//   Its tail qualifies tree_max. Valid bits shift every cycle; there is no stall.
//  Position counter: starts at 0 at the first beat of a pass; +1 per accepted beat; wraps at 2^POS_WIDTH.
//  Score compare uses the tree rule: a negative score (MSB=1) is treated as 0.
//   Update when tail valid && clamp(tree_max).mag > running.mag (strict). On a tie, keep the earlier pos.
//  Running max is cleared to 0/pos 0 at the first accepted beat of a pass, not at its tail.
//   If that beat's tail compares equal to 0, best_pos=its pos.
//  FSM:
//   IDLE : beat_ready=1. An accepted beat -> ACCUM.
//    An accepted beat with beat_last=1 -> DRAIN.
//   ACCUM: beat_ready=1. An accepted beat with beat_last -> DRAIN.
//   DRAIN: beat_ready=0. Wait until the tail holds last (TREE_LAT cycles after the last beat).
//    Fold that tail value in, then -> HOLD.
//   HOLD : res_valid=1; beat_ready=0. Outputs are stable while res_ready=0.
//    res_valid&res_ready -> IDLE. res_valid drops the next cycle.
//  Latency: res_valid rises TREE_LAT+1 cycles after the accepted last beat.
//  Single-beat pass (valid&last in IDLE) is legal and yields pos 0.
//  beat_last without beat_valid is ignored.
//  beat_valid while beat_ready=0: the beat is discarded, drop_err is set until reset, and state is unaffected.
//  Async reset mid-pass aborts the pass: pending tails are discarded and no result is produced.
// STRUCTURE
//  Shared package/util include: DATA_WIDTH, POS_WIDTH defaults, TREE_LAT constant.
//   Also a score_clamp/score_gt function implementing the sign-flag compare, so it stays identical to the tree.
//  One sub-module: score_lat_pipe (TREE_LAT-deep {valid,last,pos} shift register, async reset).
//  FSM + running max + output regs in the top module. The tree itself is NOT instantiated here.
// TESTING
//  1 4 beats, tree_max 5,9,9,3 at TREE_LAT offsets, last on beat 3
//    -> res_valid 3 cycles after the last beat; best_score=9, best_pos=1 (tie keeps earliest).
//  2 All tree_max negative (MSB=1), 3 beats -> best_score=0, best_pos=0.
//  3 Hold res_ready=0 for 5 cycles in HOLD -> outputs stable, beat_ready=0.
//    Then ready=1 -> IDLE next cycle; a new pass restarts at pos 0.
//  4 Single beat valid&last with tree_max=17 -> best_score=17, best_pos=0.
//  5 beat_valid asserted during DRAIN -> drop_err=1 (sticky); result unchanged.
//  6 Assert rst_n=0 mid-ACCUM after 2 beats -> all outputs at reset values.
//    Next full pass is unaffected by the aborted beats.

Source files
------------

// File: rtl/score_max_tracker_pkg.sv
// Shared constants and the sign-flag score compare used by the max-reduction tree,
// kept here so the tracker folds scores with exactly the same rule as the tree.
package score_max_tracker_pkg;

  localparam int SCORE_W  = 18;
  localparam int POS_W    = 8;
  localparam int TREE_LAT = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  typedef logic [SCORE_W-1:0] score_t;

  // MSB is a sign flag: any flagged score counts as zero.
  function automatic score_t score_clamp(input score_t s);
    return s[SCORE_W-1] ? '0 : s;
  endfunction

  function automatic logic score_gt(input score_t a, input score_t b);
    score_t ca;
    score_t cb;
    ca = score_clamp(a);
    cb = score_clamp(b);
    return ca[SCORE_W-2:0] > cb[SCORE_W-2:0];
  endfunction

endpackage

// File: rtl/score_lat_pipe.sv
// Delay line that carries {valid,last,pos} alongside the reduction tree so the
// tail lines up with the tree result for the same beat. Never stalls.
module score_lat_pipe
  import score_max_tracker_pkg::*;
#(
  parameter int DEPTH     = TREE_LAT,
  parameter int POS_WIDTH = POS_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic [POS_WIDTH-1:0] in_pos,
  output logic                 tail_valid,
  output logic                 tail_last,
  output logic [POS_WIDTH-1:0] tail_pos
);

  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [DEPTH-1:0]     last_q, last_d;
  logic [POS_WIDTH-1:0] pos_q [DEPTH];
  logic [POS_WIDTH-1:0] pos_d [DEPTH];

  always_comb begin
    valid_d[0] = in_valid;
    last_d[0]  = in_last;
    pos_d[0]   = in_pos;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      last_d[i]  = last_q[i-1];
      pos_d[i]   = pos_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      last_q  <= '0;
      for (int i = 0; i < DEPTH; i++) pos_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
      for (int i = 0; i < DEPTH; i++) pos_q[i] <= pos_d[i];
    end
  end

  assign tail_valid = valid_q[DEPTH-1];
  assign tail_last  = last_q[DEPTH-1];
  assign tail_pos   = pos_q[DEPTH-1];

endmodule

// File: rtl/score_max_tracker.sv
// Tracks the best clamped score of a query pass and the beat where it first
// appears, then hands {best_score, best_pos} to the host on valid/ready.
module score_max_tracker
  import score_max_tracker_pkg::*;
#(
  parameter int DATA_WIDTH = SCORE_W,
  parameter int POS_WIDTH  = POS_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  beat_valid,
  input  logic                  beat_last,
  output logic                  beat_ready,
  input  logic [DATA_WIDTH-1:0] tree_max,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] best_score,
  output logic [POS_WIDTH-1:0]  best_pos,
  output logic                  drop_err
);

  logic [1:0]            state_q, state_d;
  logic [POS_WIDTH-1:0]  pos_cnt_q, pos_cnt_d;
  logic [DATA_WIDTH-1:0] best_score_q, best_score_d;
  logic [POS_WIDTH-1:0]  best_pos_q, best_pos_d;
  logic                  drop_err_q, drop_err_d;

  logic                  beat_acc;
  logic                  first_beat;
  logic [POS_WIDTH-1:0]  beat_pos;
  logic                  tail_valid;
  logic                  tail_last;
  logic [POS_WIDTH-1:0]  tail_pos;

  assign beat_ready = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
  assign beat_acc   = beat_valid && beat_ready;
  assign first_beat = beat_acc && (state_q == ST_IDLE);
  assign beat_pos   = first_beat ? '0 : pos_cnt_q;

  score_lat_pipe #(
    .DEPTH     (TREE_LAT),
    .POS_WIDTH (POS_WIDTH)
  ) u_lat_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (beat_acc),
    .in_last    (beat_last),
    .in_pos     (beat_pos),
    .tail_valid (tail_valid),
    .tail_last  (tail_last),
    .tail_pos   (tail_pos)
  );

  // The running max is reset when a pass opens; its own tail arrives later and
  // only wins against zero with a strictly greater score.
  always_comb begin
    pos_cnt_d    = pos_cnt_q;
    best_score_d = best_score_q;
    best_pos_d   = best_pos_q;
    drop_err_d   = drop_err_q | (beat_valid & ~beat_ready);
    state_d      = state_q;

    if (beat_acc) pos_cnt_d = beat_pos + POS_WIDTH'(1);

    if (first_beat) begin
      best_score_d = '0;
      best_pos_d   = '0;
    end else if (tail_valid && score_gt(tree_max, best_score_q)) begin
      best_score_d = score_clamp(tree_max);
      best_pos_d   = tail_pos;
    end

    case (state_q)
      ST_IDLE:  if (beat_acc) state_d = beat_last ? ST_DRAIN : ST_ACCUM;
      ST_ACCUM: if (beat_acc && beat_last) state_d = ST_DRAIN;
      ST_DRAIN: if (tail_valid && tail_last) state_d = ST_HOLD;
      ST_HOLD:  if (res_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pos_cnt_q    <= '0;
      best_score_q <= '0;
      best_pos_q   <= '0;
      drop_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_cnt_q    <= pos_cnt_d;
      best_score_q <= best_score_d;
      best_pos_q   <= best_pos_d;
      drop_err_q   <= drop_err_d;
    end
  end

  assign res_valid  = (state_q == ST_HOLD);
  assign best_score = best_score_q;
  assign best_pos   = best_pos_q;
  assign drop_err   = drop_err_q;

endmodule

// File: tb/tb_score_max_tracker.sv
// Directed bench for score_max_tracker: tree results are driven by hand
// TREE_LAT cycles after each beat and every expected value is precomputed.
module tb_score_max_tracker;
  import score_max_tracker_pkg::*;

  localparam int DW = SCORE_W;
  localparam int PW = POS_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          beat_valid = 1'b0;
  logic          beat_last = 1'b0;
  logic          res_ready = 1'b0;
  logic [DW-1:0] tree_max = '0;
  logic          beat_ready;
  logic          res_valid;
  logic [DW-1:0] best_score;
  logic [PW-1:0] best_pos;
  logic          drop_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  score_max_tracker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .beat_valid (beat_valid),
    .beat_last  (beat_last),
    .beat_ready (beat_ready),
    .tree_max   (tree_max),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .best_score (best_score),
    .best_pos   (best_pos),
    .drop_err   (drop_err)
  );

  // Drive one cycle of inputs, then land 1 time unit after the sampling edge.
  task automatic applyStimulus(input logic bv, input logic bl,
                               input logic [DW-1:0] tm, input logic rr);
    beat_valid = bv;
    beat_last  = bl;
    tree_max   = tm;
    res_ready  = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkResult(input string tag, input logic [31:0] score,
                             input logic [31:0] pos);
    checkOutput({tag, "_valid"}, 32'(res_valid), 32'd1);
    checkOutput({tag, "_score"}, 32'(best_score), score);
    checkOutput({tag, "_pos"}, 32'(best_pos), pos);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_ready", 32'(beat_ready), 32'd1);
    checkOutput("rst_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_score", 32'(best_score), 32'd0);
    checkOutput("rst_pos", 32'(best_pos), 32'd0);
    checkOutput("rst_drop", 32'(drop_err), 32'd0);
    #10 rst_n = 1'b1;

    $display("[TB] beat_last without beat_valid");
    applyStimulus(1'b0, 1'b1, 18'd0, 1'b0);
    checkOutput("lastonly_ready", 32'(beat_ready), 32'd1);

    $display("[TB] four beats 5,9,9,3");
    applyStimulus(1'b1, 1'b0, 18'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 18'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 18'd5, 1'b0);
    applyStimulus(1'b1, 1'b1, 18'd9, 1'b0);
    checkOutput("t1_drain_ready", 32'(beat_ready), 32'd0);
    applyStimulus(1'b0, 1'b0, 18'd9, 1'b0);
    checkOutput("t1_early_valid", 32'(res_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 18'd3, 1'b0);
    checkResult("t1", 32'd9, 32'd1);
    applyStimulus(1'b0, 1'b0, 18'd0, 1'b1);
    checkOutput("t1_done_valid", 32'(res_valid), 32'd0);
    checkOutput("t1_done_ready", 32'(beat_ready), 32'd1);

    $display("[TB] all-negative pass");
    applyStimulus(1'b1, 1'b0, 18'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 18'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 18'h3FFFF, 1'b0);
    applyStimulus(1'b0, 1'b0, 18'h20100, 1'b0);
    applyStimulus(1'b0, 1'b0, 18'h2ABCD, 1'b0);
    checkResult("t2", 32'd0, 32'd0);
    applyStimulus(1'b0, 1'b0, 18'd0, 1'b1);

    $display("[TB] result held under backpressure");
    applyStimulus(1'b1, 1'b0, 18'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 18'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 18'd4, 1'b0);
    applyStimulus(1'b0, 1'b0, 18'd7, 1'b0);
    checkResult("t3", 32'd7, 32'd1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 18'd99, 1'b0);
      checkResult("t3_hold", 32'd7, 32'd1);
      checkOutput("t3_hold_ready", 32'(beat_ready), 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 18'd0, 1'b1);
    checkOutput("t3_idle_valid", 32'(res_valid), 32'd0);
    checkOutput("t3_idle_ready", 32'(beat_ready), 32'd1);
    applyStimulus(1'b1, 1'b0, 18'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 18'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 18'd2, 1'b0);
    applyStimulus(1'b0, 1'b0, 18'd6, 1'b0);
    checkResult("t3_restart", 32'd6, 32'd1);
    applyStimulus(1'b0, 1'b0, 18'd0, 1'b1);

    $display("[TB] single-beat pass");
    applyStimulus(1'b1, 1'b1, 18'd0, 1'b0);
    checkOutput("t4_ready", 32'(beat_ready), 32'd0);
    applyStimulus(1'b0, 1'b0, 18'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 18'd17, 1'b0);
    checkResult("t4", 32'd17, 32'd0);
    applyStimulus(1'b0, 1'b0, 18'd0, 1'b1);

    $display("[TB] beat offered during drain");
    checkOutput("t5_drop_before", 32'(drop_err), 32'd0);
    applyStimulus(1'b1, 1'b0, 18'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 18'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 18'd3, 1'b0);
    checkOutput("t5_drop", 32'(drop_err), 32'd1);
    checkOutput("t5_drain_valid", 32'(res_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 18'd8, 1'b0);
    checkResult("t5", 32'd8, 32'd1);
    applyStimulus(1'b0, 1'b0, 18'd0, 1'b1);
    checkOutput("t5_drop_sticky", 32'(drop_err), 32'd1);

    $display("[TB] reset mid-pass");
    applyStimulus(1'b1, 1'b0, 18'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 18'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 18'd50, 1'b0);
    checkOutput("t6_pre_score", 32'(best_score), 32'd50);
    beat_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_ready", 32'(beat_ready), 32'd1);
    checkOutput("t6_rst_valid", 32'(res_valid), 32'd0);
    checkOutput("t6_rst_score", 32'(best_score), 32'd0);
    checkOutput("t6_rst_pos", 32'(best_pos), 32'd0);
    checkOutput("t6_rst_drop", 32'(drop_err), 32'd0);
    #1 rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 18'd60, 1'b0);
    applyStimulus(1'b1, 1'b1, 18'd60, 1'b0);
    applyStimulus(1'b0, 1'b0, 18'd4, 1'b0);
    applyStimulus(1'b0, 1'b0, 18'd6, 1'b0);
    checkResult("t6_after", 32'd6, 32'd1);
    applyStimulus(1'b0, 1'b0, 18'd0, 1'b1);
    checkOutput("t6_done_valid", 32'(res_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
